hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//   Pipeline hazard controller for the 5-stage RV32I core. Sole producer of the
//   ForwardAE/ForwardBE selects consumed by the execute stage, plus stall/flush
//   for the F/D, D/E, E/M and M/W registers. Detects RAW forwarding, load-use and
//   control hazards, and freezes the pipe on a multi-cycle data-memory access
//   with a timeout watchdog and a saturating stall-cycle counter.
// PARAMETERS
//   REG_FILE_ADDRESS_WIDTH  5     register index width
//   TIMEOUT_CYCLES          255   max MEM_WAIT cycles before entering ERROR
//   CNT_WIDTH               32    width of StallCount
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   Rs1D,Rs2D  in   5   source regs of instruction in Decode
//   Rs1E,Rs2E  in   5   source regs of instruction in Execute
//   RdE,RdM,RdW in  5   destination regs in E / M / W
//   RegWriteM,RegWriteW in 1  writeback enables in M / W
//   ResultSrcE0 in  1   instruction in E is a load
//   PCSrcE     in   1   branch taken / jump resolved in E
//   MemReqM    in   1   load/store in M issuing a data-memory request
//   MemReadyM  in   1   data memory completes the request this cycle
//   ForwardAE,ForwardBE out 2  00 regfile, 01 ResultW, 10 ALUResultM, 11 never
//   StallF,StallD,StallE,StallM out 1  hold the corresponding pipeline register
//   FlushD,FlushE out 1  clear F/D, D/E register to NOP on next edge
//   BubbleW    out  1   M/W register loads a NOP (RegWrite=0)
//   MemTimeout out  1   sticky: watchdog expired
//   StallCount out  CNT_WIDTH  total frozen cycles (load-use + MEM_WAIT), saturating
// BEHAVIOUR
//   Reset (rst_n=0, async): state=RUN, wait counter=0, StallCount=0, MemTimeout=0;
//     while low, every output forced 0 (ForwardxE=00).
//   Forwarding (comb, every state): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E;
//     else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. Same for B with Rs2E.
//     M priority over W. x0 never forwarded.
//   lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
//   memWait = MemReqM & !MemReadyM.
//   FSM states RUN, MEM_WAIT, ERROR:
//     RUN: memWait -> MEM_WAIT (freeze asserted same cycle, comb); else stay.
//       Outputs: StallF=StallD=lwStall&!PCSrcE; FlushD=PCSrcE;
//       FlushE=lwStall|PCSrcE; StallE=StallM=BubbleW=0.
//     MEM_WAIT: StallF=StallD=StallE=StallM=1, BubbleW=1, FlushD=FlushE=0
//       (control/load-use decisions deferred; inputs are frozen so re-evaluated
//       in RUN). Counter increments each cycle. MemReadyM=1 -> RUN, counter=0,
//       freeze deasserts that same cycle. Counter==TIMEOUT_CYCLES & !MemReadyM
//       -> ERROR, MemTimeout<=1.
//     ERROR: all four stalls=1, BubbleW=1, flushes=0; exit only by reset.
//   memWait in RUN overrides lwStall/PCSrcE for that cycle (freeze wins).
//   StallCount += 1 on any cycle with StallF=1; holds at all-ones.
//   Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared.
// TESTING
//   1 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 -> 01.
//   2 RdE=7,ResultSrcE0=1,Rs2D=7 -> StallF=StallD=1,FlushE=1, StallCount 0->1;
//     same with RdE=0 -> no stall.
//   3 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0.
//   4 MemReqM=1,MemReadyM=0 for 3 cycles then 1 -> StallF..M=BubbleW=1 for 3
//     cycles, 0 on ready cycle; StallCount=3; state RUN.
//   5 TIMEOUT_CYCLES=4, MemReadyM held 0 -> MemTimeout=1 after cycle 5, stalls
//     stay 1 with MemReadyM=1; rst_n pulse -> all outputs 0, MemTimeout=0.
//   6 rst_n low during MEM_WAIT (async, mid-cycle) -> stalls drop immediately.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: pipeline-side bundle of hazard detection inputs and control outputs
interface hazard_if #(
  parameter int AW = 5,
  parameter int CW = 32
);
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, MemTimeout;
  logic [CW-1:0] StallCount;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, BubbleW, MemTimeout, StallCount
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, BubbleW, MemTimeout, StallCount
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use/control hazards and memory-wait freeze with watchdog
module hazard_unit #(
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int TIMEOUT_CYCLES         = 255,
  parameter int CNT_WIDTH              = 32
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 lw_stall, mem_wait, frz, stall_fd;
  function automatic logic [1:0] fwd(
    input logic [REG_FILE_ADDRESS_WIDTH-1:0] rs, rdm, rdw,
    input logic wm, ww
  );
    return (wm && rdm != '0 && rdm == rs) ? 2'b10 :
           (ww && rdw != '0 && rdw == rs) ? 2'b01 : 2'b00;
  endfunction
  // hazard detection and output decode; a freeze overrides load-use and redirect decisions
  always_comb begin
    lw_stall = hz.ResultSrcE0 && hz.RdE != '0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    mem_wait = hz.MemReqM && !hz.MemReadyM;
    frz      = state_q == ERROR || (state_q == MEM_WAIT && !hz.MemReadyM) ||
               (state_q == RUN && mem_wait);
    stall_fd = frz || (lw_stall && !hz.PCSrcE);
    hz.ForwardAE  = rst_n ? fwd(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : 2'b00;
    hz.ForwardBE  = rst_n ? fwd(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : 2'b00;
    hz.StallF     = rst_n && stall_fd;
    hz.StallD     = rst_n && stall_fd;
    hz.StallE     = rst_n && frz;
    hz.StallM     = rst_n && frz;
    hz.BubbleW    = rst_n && frz;
    hz.FlushD     = rst_n && !frz && hz.PCSrcE;
    hz.FlushE     = rst_n && !frz && (lw_stall || hz.PCSrcE);
    hz.MemTimeout = tmo_q;
    hz.StallCount = cnt_q;
  end
  // next state: the wait counter starts at 1 on entry so it counts every frozen memory cycle
  always_comb begin
    state_d = state_q == RUN      ? (mem_wait ? MEM_WAIT : RUN) :
              state_q == MEM_WAIT ? (hz.MemReadyM ? RUN :
                                     wait_q == WW'(TIMEOUT_CYCLES) ? ERROR : MEM_WAIT) : ERROR;
    wait_d  = state_d == MEM_WAIT ? wait_q + WW'(1) : state_d == ERROR ? wait_q : '0;
    tmo_d   = tmo_q || state_d == ERROR;
    cnt_d   = (stall_fd && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of forwarding, stalls, flushes, freeze, watchdog and reset
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst_n;
  int errs = 0;
  int n = 0;
  always #5 clk = ~clk;
  hazard_if #(.AW(5), .CW(32)) hif ();
  hazard_if #(.AW(5), .CW(2))  hif2 ();
  hazard_unit #(.REG_FILE_ADDRESS_WIDTH(5), .TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hif.slave)
  );
  hazard_unit #(.REG_FILE_ADDRESS_WIDTH(5), .TIMEOUT_CYCLES(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hz(hif2.slave)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
    hif.RegWriteM = 0; hif.RegWriteW = 0; hif.ResultSrcE0 = 0;
    hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemReadyM = 0;
  endtask
  initial begin
    hif2.Rs1D = 0; hif2.Rs2D = 0; hif2.Rs1E = 0; hif2.Rs2E = 0;
    hif2.RdE = 0; hif2.RdM = 0; hif2.RdW = 0;
    hif2.RegWriteM = 0; hif2.RegWriteW = 0; hif2.ResultSrcE0 = 0;
    hif2.PCSrcE = 0; hif2.MemReqM = 0; hif2.MemReadyM = 0;
    clr();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    hif.RegWriteM = 1; hif.RdM = 5; hif.Rs1E = 5; hif.MemReqM = 1;
    #1;
    chk("rst_fwdA", hif.ForwardAE, 0);
    chk("rst_stallF", hif.StallF, 0);
    chk("rst_bubble", hif.BubbleW, 0);
    chk("rst_cnt", hif.StallCount, 0);
    chk("rst_tmo", hif.MemTimeout, 0);
    @(negedge clk); clr(); rst_n = 1'b1;
    hif.RegWriteM = 1; hif.RdM = 5; hif.RegWriteW = 1; hif.RdW = 5; hif.Rs1E = 5; hif.Rs2E = 5;
    #1;
    chk("fwdA_M", hif.ForwardAE, 2'b10);
    chk("fwdB_M", hif.ForwardBE, 2'b10);
    hif.RdM = 0; #1;
    chk("fwdA_W", hif.ForwardAE, 2'b01);
    hif.RegWriteW = 0; #1;
    chk("fwdA_none", hif.ForwardAE, 2'b00);
    hif.RegWriteW = 1; hif.RdW = 0; hif.Rs1E = 0; #1;
    chk("fwdA_x0", hif.ForwardAE, 2'b00);
    @(negedge clk); clr();
    hif.RdE = 7; hif.ResultSrcE0 = 1; hif.Rs2D = 7; #1;
    chk("lw_stallF", hif.StallF, 1);
    chk("lw_stallD", hif.StallD, 1);
    chk("lw_flushE", hif.FlushE, 1);
    chk("lw_flushD", hif.FlushD, 0);
    chk("lw_stallE", hif.StallE, 0);
    @(posedge clk); #1;
    chk("lw_cnt", hif.StallCount, 1);
    @(negedge clk); hif.RdE = 0; hif.Rs2D = 0; #1;
    chk("lw_x0_stallF", hif.StallF, 0);
    chk("lw_x0_flushE", hif.FlushE, 0);
    @(posedge clk); #1;
    chk("lw_x0_cnt", hif.StallCount, 1);
    @(negedge clk); hif.RdE = 7; hif.Rs2D = 7; hif.PCSrcE = 1; #1;
    chk("br_flushD", hif.FlushD, 1);
    chk("br_flushE", hif.FlushE, 1);
    chk("br_stallF", hif.StallF, 0);
    chk("br_stallD", hif.StallD, 0);
    @(posedge clk); #1;
    chk("br_cnt", hif.StallCount, 1);
    @(negedge clk); hif.MemReqM = 1; hif.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_stallF", hif.StallF, 1);
      chk("frz_stallM", hif.StallM, 1);
      chk("frz_bubble", hif.BubbleW, 1);
      chk("frz_flushD", hif.FlushD, 0);
      chk("frz_flushE", hif.FlushE, 0);
      @(negedge clk);
    end
    hif.MemReadyM = 1; #1;
    chk("rdy_stallE", hif.StallE, 0);
    chk("rdy_bubble", hif.BubbleW, 0);
    chk("rdy_stallF", hif.StallF, 0);
    chk("rdy_flushD", hif.FlushD, 1);
    @(posedge clk); #1;
    chk("rdy_cnt", hif.StallCount, 4);
    @(negedge clk); clr(); hif.MemReqM = 1; hif.MemReadyM = 1; #1;
    chk("run_hit_stallF", hif.StallF, 0);
    @(negedge clk); clr(); hif.MemReqM = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("tmo_early", hif.MemTimeout, 0);
    @(posedge clk); #1;
    chk("tmo_set", hif.MemTimeout, 1);
    chk("tmo_cnt", hif.StallCount, 9);
    @(negedge clk); hif.MemReadyM = 1; #1;
    chk("err_stallF", hif.StallF, 1);
    chk("err_stallE", hif.StallE, 1);
    chk("err_bubble", hif.BubbleW, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst2_stallF", hif.StallF, 0);
    chk("rst2_bubble", hif.BubbleW, 0);
    chk("rst2_tmo", hif.MemTimeout, 0);
    chk("rst2_cnt", hif.StallCount, 0);
    @(negedge clk); clr(); rst_n = 1'b1; hif.MemReqM = 1; hif.MemReadyM = 1; #1;
    chk("rst2_run", hif.StallF, 0);
    @(negedge clk); clr(); hif.MemReqM = 1;
    @(posedge clk); #1;
    chk("mw_stallE", hif.StallE, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_stallE", hif.StallE, 0);
    chk("async_stallF", hif.StallF, 0);
    chk("async_cnt", hif.StallCount, 0);
    @(negedge clk); clr(); rst_n = 1'b1; hif.MemReqM = 1; hif.MemReadyM = 1; #1;
    chk("async_run", hif.StallF, 0);
    @(negedge clk); hif2.MemReqM = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_cnt2", hif2.StallCount, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_cnt3", hif2.StallCount, 3);
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
